// File: rtl/rnd_sticky_stage.sv
// rnd_sticky_stage
//   Two-register rounder stage placed after the mask generator. It applies the
//   keep-mask v and the drop-mask w to the shifted significand fs. The results
//   are the retained significand fk, the round bit r and the sticky bit s.
//   Stage 1 pre-reduces the sticky bits into W/G group ORs, and stage 2
//   finishes the reduction. The valid/ready handshake sustains one operand per
//   cycle.
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   in_valid/in_ready   upstream handshake
//   fs, v, w            shifted significand, keep-mask, drop-mask
//                       (w is a contiguous run of ones from bit 0, or all zero)
//   tag_in / tag_out    sideband (sign, exponent, rounding mode), delayed
//   out_valid/out_ready downstream handshake
//   fk, r, s            retained significand, round bit, sticky bit
module rnd_sticky_stage #(
  parameter int W     = 64,
  parameter int G     = 16,
  parameter int TAG_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     fs,
  input  logic [W-1:0]     v,
  input  logic [W-1:0]     w,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     fk,
  output logic             r,
  output logic             s,
  output logic [TAG_W-1:0] tag_out
);

  localparam int NG = W / G;

  // stage 1 combinational
  logic [W-1:0]  w_rpos;
  logic [W-1:0]  w_sm;
  logic          w_r1;
  logic [NG-1:0] w_g;
  logic          w_ld1;
  logic          w_ld2;

  // pipeline registers
  logic             r_s1_valid;
  logic             r_s2_valid;
  logic [W-1:0]     r_fk1;
  logic             r_r1;
  logic [NG-1:0]    r_g;
  logic [TAG_W-1:0] r_tag1;
  logic [W-1:0]     r_fk;
  logic             r_r;
  logic             r_s;
  logic [TAG_W-1:0] r_tag;

  // Because w is a contiguous run from bit 0, the round position is its top one.
  // Everything below that position in the run feeds the sticky bit.
  assign w_rpos = w & ~(w >> 1);
  assign w_r1   = |(fs & w_rpos);
  assign w_sm   = fs & (w >> 1);

  for (genvar gi = 0; gi < NG; gi++) begin : g_grp
    assign w_g[gi] = |w_sm[gi*G +: G];
  end

  // Stage 2 frees up when it is empty or is handing off this edge. Stage 1
  // frees up when it is empty or is moving into stage 2.
  assign w_ld2    = r_s1_valid && (!r_s2_valid || out_ready);
  assign in_ready = !r_s1_valid || !r_s2_valid || out_ready;
  assign w_ld1    = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      if (w_ld1)      r_s1_valid <= 1'b1;
      else if (w_ld2) r_s1_valid <= 1'b0;

      if (w_ld2)          r_s2_valid <= 1'b1;
      else if (out_ready) r_s2_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fk1  <= '0;
      r_r1   <= 1'b0;
      r_g    <= '0;
      r_tag1 <= '0;
    end else if (w_ld1) begin
      r_fk1  <= fs & v;
      r_r1   <= w_r1;
      r_g    <= w_g;
      r_tag1 <= tag_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fk  <= '0;
      r_r   <= 1'b0;
      r_s   <= 1'b0;
      r_tag <= '0;
    end else if (w_ld2) begin
      r_fk  <= r_fk1;
      r_r   <= r_r1;
      r_s   <= |r_g;
      r_tag <= r_tag1;
    end
  end

  assign out_valid = r_s2_valid;
  assign fk        = r_fk;
  assign r         = r_r;
  assign s         = r_s;
  assign tag_out   = r_tag;

endmodule

// File: tb/tb_rnd_sticky_stage.sv
module tb_rnd_sticky_stage;

  logic        clk, rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [63:0] fs, v, w, fk;
  logic        r, s;
  logic [15:0] tag_in, tag_out;

  rnd_sticky_stage #(.W(64), .G(16), .TAG_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .fs(fs), .v(v), .w(w), .tag_in(tag_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .fk(fk), .r(r), .s(s), .tag_out(tag_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] fk;
    logic        r;
    logic        s;
    logic [15:0] tag;
  } exp_t;

  typedef struct {
    logic [63:0] fs, v, w;
    logic [15:0] tag;
    logic [63:0] fk;
    logic        r, s;
  } vec_t;

  int   n_chk = 0, n_fail = 0, n_out = 0;
  exp_t q[$];
  exp_t mon_e;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: w is a run of n ones, so the round bit is fs[n-1] and the
  // sticky bit is the OR of fs[n-2:0].
  function automatic exp_t model(input logic [63:0] f, vv, ww, input logic [15:0] t);
    exp_t e;
    int   n;
    n     = $countones(ww);
    e.fk  = f & vv;
    e.tag = t;
    if (n == 0) begin
      e.r = 1'b0;
      e.s = 1'b0;
    end else begin
      e.r = f[n-1];
      e.s = (n > 1) ? ((f & ((64'd1 << (n-1)) - 64'd1)) != 64'd0) : 1'b0;
    end
    return e;
  endfunction

  // Scoreboard: handshakes are stable at the falling edge and complete on the
  // next rising edge.
  always @(negedge clk) begin
    if (!rst_n) q.delete();
    else begin
      if (out_valid && out_ready) begin
        n_out++;
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_output: got fk=%h tag=%h expected none", fk, tag_out);
        end else begin
          mon_e = q.pop_front();
          chk("sb_fk", fk, mon_e.fk);
          chk("sb_r", {63'd0, r}, {63'd0, mon_e.r});
          chk("sb_s", {63'd0, s}, {63'd0, mon_e.s});
          chk("sb_tag", {48'd0, tag_out}, {48'd0, mon_e.tag});
        end
      end
      if (in_valid && in_ready) q.push_back(model(fs, v, w, tag_in));
    end
  end

  task automatic send(input logic [63:0] f, vv, ww, input logic [15:0] t);
    int k;
    bit acc;
    fs = f; v = vv; w = ww; tag_in = t; in_valid = 1'b1;
    k = 0;
    acc = 1'b0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      k++;
    end while (!acc && k < 100);
    if (!acc) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: got no accept expected accept within 100 cycles");
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (q.size() != 0 && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  function automatic logic [63:0] rand_w();
    int n;
    n = $urandom_range(0, 64);
    return (n == 64) ? {64{1'b1}} : ((64'd1 << n) - 64'd1);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1);
  end

  vec_t tbl[10];
  exp_t e0;
  logic [63:0] rf, rw, rv;
  int c0, n0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    tbl[0] = '{64'h180, ~64'hFF, 64'hFF, 16'h1234, 64'h100, 1'b1, 1'b0};
    tbl[1] = '{64'h141, ~64'hFF, 64'hFF, 16'h0002, 64'h100, 1'b0, 1'b1};
    tbl[2] = '{64'h10000, ~64'h1FFFF, 64'h1FFFF, 16'h0003, 64'h0, 1'b1, 1'b0};
    tbl[3] = '{64'h18000, ~64'h1FFFF, 64'h1FFFF, 16'h0004, 64'h0, 1'b1, 1'b1};
    tbl[4] = '{64'h8000, ~64'hFFFF, 64'hFFFF, 16'h0005, 64'h0, 1'b1, 1'b0};
    tbl[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 16'hA5A5,
               64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
    tbl[6] = '{64'h8000_0000_0000_0001, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 16'h0007,
               64'h0, 1'b1, 1'b1};
    tbl[7] = '{64'h4000_0000_0000_0000, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 16'h0008,
               64'h0, 1'b0, 1'b1};
    tbl[8] = '{64'h1_0000_0000, ~64'h1_FFFF_FFFF, 64'h1_FFFF_FFFF, 16'h0009,
               64'h0, 1'b1, 1'b0};
    tbl[9] = '{64'hDEAD_BEEF_0000_0000, ~64'hFFFF_FFFF, 64'hFFFF_FFFF, 16'hBEEF,
               64'hDEAD_BEEF_0000_0000, 1'b0, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    fs = '0; v = '0; w = '0; tag_in = '0;
    #3;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_fk", fk, 64'd0);
    chk("rst_r", {63'd0, r}, 64'd0);
    chk("rst_s", {63'd0, s}, 64'd0);
    chk("rst_tag", {48'd0, tag_out}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

    // directed vectors, one at a time, with the 2-cycle latency checked
    for (int i = 0; i < 10; i++) begin
      chk("tbl_in_ready", {63'd0, in_ready}, 64'd1);
      fs = tbl[i].fs; v = tbl[i].v; w = tbl[i].w; tag_in = tbl[i].tag; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("tbl_lat1_valid", {63'd0, out_valid}, 64'd0);
      @(posedge clk);
      #1;
      chk("tbl_lat2_valid", {63'd0, out_valid}, 64'd1);
      chk("tbl_fk", fk, tbl[i].fk);
      chk("tbl_r", {63'd0, r}, {63'd0, tbl[i].r});
      chk("tbl_s", {63'd0, s}, {63'd0, tbl[i].s});
      chk("tbl_tag", {48'd0, tag_out}, {48'd0, tbl[i].tag});
    end
    drain();

    // backpressure: two accepts fill the pipe, then outputs must hold
    out_ready = 1'b0;
    e0 = model(64'h180, ~64'hFF, 64'hFF, 16'h0B00);
    send(64'h180, ~64'hFF, 64'hFF, 16'h0B00);
    send(64'h141, ~64'hFF, 64'hFF, 16'h0B01);
    chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
    chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
    fork
      begin
        send(64'h18000, ~64'h1FFFF, 64'h1FFFF, 16'h0B02);
        send(64'hFFFF_0000_1234_5678, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 16'h0B03);
        send(64'h8000_0000_0000_0001, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 16'h0B04);
      end
      begin
        repeat (3) begin
          @(posedge clk);
          #2;
          chk("bp_hold_in_ready", {63'd0, in_ready}, 64'd0);
          chk("bp_hold_valid", {63'd0, out_valid}, 64'd1);
          chk("bp_hold_fk", fk, e0.fk);
          chk("bp_hold_r", {63'd0, r}, {63'd0, e0.r});
          chk("bp_hold_s", {63'd0, s}, {63'd0, e0.s});
          chk("bp_hold_tag", {48'd0, tag_out}, {48'd0, e0.tag});
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // full throughput: 20 random operands back to back
    c0 = cyc;
    n0 = n_out;
    for (int i = 0; i < 20; i++) begin
      rf = {$urandom, $urandom};
      rw = rand_w();
      rv = ($urandom_range(0, 1) == 1) ? ~rw : {$urandom, $urandom};
      send(rf, rv, rw, 16'($urandom));
    end
    chk("tp_accept_cycles", 64'(cyc - c0), 64'd20);
    repeat (2) @(posedge clk);
    #1;
    chk("tp_out_count", 64'(n_out - n0), 64'd20);
    drain();

    // reset with both stages full: everything in flight is dropped
    out_ready = 1'b0;
    send(64'h180, ~64'hFF, 64'hFF, 16'h0C00);
    send(64'h141, ~64'hFF, 64'hFF, 16'h0C01);
    chk("mr_pre_valid", {63'd0, out_valid}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mr_out_valid", {63'd0, out_valid}, 64'd0);
    chk("mr_fk", fk, 64'd0);
    chk("mr_r", {63'd0, r}, 64'd0);
    chk("mr_s", {63'd0, s}, 64'd0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    chk("mr_in_ready", {63'd0, in_ready}, 64'd1);
    repeat (4) begin
      @(posedge clk);
      #1;
      chk("mr_no_stale", {63'd0, out_valid}, 64'd0);
    end
    chk("mr_queue_empty", 64'(q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rnd_sticky_stage.md
Name: rnd_sticky_stage

Overview:
- Pipelined rounder stage that sits directly downstream of the rounder mask generator.
- Applies the keep-mask v and drop-mask w to an already-shifted significand.
- Produces the retained significand, the round bit r and the sticky bit s for the rounding-decision stage.
- Two register stages with a valid/ready handshake; full throughput of one operand per cycle.

Parameters:
- W, 64, significand / mask width; must be a multiple of G.
- G, 16, sticky pre-reduction group width in stage 1; W/G groups.
- TAG_W, 16, width of sideband tag (sign, exponent, rounding mode) carried alongside the operand.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream operand valid.
- in_ready  output  1  stage can accept an operand this cycle.
- fs  input  W  shifted significand.
- v  input  W  keep-mask from the mask generator.
- w  input  W  drop-mask from the mask generator; a contiguous run of ones from bit 0 up, or all zero.
- tag_in  input  TAG_W  sideband, passed through unchanged.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- fk  output  W  retained significand, fs & v.
- r  output  1  round bit.
- s  output  1  sticky bit.
- tag_out  output  TAG_W  delayed tag_in.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Both stage valid flags clear; out_valid = 0.
  - fk, r, s, tag_out and all internal data registers = 0.
  - in_ready = 1 once rst_n is high.
- Transfer rule: a transfer occurs on a rising edge when valid and ready are both high on that interface.
- Stage 1 loads when in_valid && in_ready. It registers:
  - fk1 = fs & v.
  - rpos = w & ~(w >> 1), the MSB of the drop region.
  - r1 = |(fs & rpos).
  - g[i] = |(fs & (w >> 1))[i*G +: G] for i = 0..W/G-1.
  - tag1 = tag_in.
- Stage 2 loads from stage 1 when s1_valid && (!s2_valid || out_ready). It registers fk = fk1, r = r1, s = |g, tag_out = tag1.
- Ready chain:
  - in_ready = !s1_valid || !s2_valid || out_ready.
  - This is combinational from out_ready. There is no combinational path from in_valid to out_valid.
- Latency and throughput:
  - Latency is exactly 2 cycles from the accept edge to out_valid high, with no stall.
  - One result per cycle when out_ready is held high.
- Stall:
  - While out_valid && !out_ready, the outputs fk, r, s and tag_out hold stable.
  - Stage 1 also holds if occupied.
  - in_ready drops only when both stages are full.
- Empty/full:
  - Stage 1 empty and stage 2 full with out_ready = 0: accepts one more operand, then in_ready = 0.
  - Simultaneous out-transfer and in-transfer with both stages full: both stages advance in the same edge; no bubble, no loss.
- w = 0 (no bits dropped): r = 0, s = 0, fk = fs & v.
- w = all ones: rpos = bit W-1; r = fs[W-1]; s = |fs[W-2:0].
- Data registers may update only on a load edge. Outputs are never X after reset.
- Reset mid-operation: all in-flight operands are discarded; no output transfer occurs for them after rst_n rises.
- Order: results leave in acceptance order; tag_out always matches its operand.

Test Plan:
- Basic: fs=0x0000_0000_0000_0180, w=0x0000_0000_0000_00FF, v=~w, tag=0x1234 -> 2 cycles later out_valid=1, fk=0x...0100, r=1, s=0, tag_out=0x1234.
- Sticky only: fs=0x0000_0000_0000_0141, same masks -> fk=0x...0100, r=0, s=1. Then fs bit 16 set with w=0x1_FFFF -> r=1, exercising the group boundary.
- Edge masks: w=0, fs=0xFFFF_FFFF_FFFF_FFFF -> r=0, s=0. w=all ones, fs=0x8000_0000_0000_0001 -> fk=0, r=1, s=1.
- Backpressure: stream 5 operands with out_ready=0 for cycles 2-6:
  - in_ready falls after 2 accepts;
  - outputs hold stable;
  - on release, all 5 emerge in order with no loss or duplication, one per cycle.
- Full throughput: out_ready=1, in_valid=1 for 20 cycles of random fs/w -> 20 results matching the reference model, back-to-back with no bubbles.
- Reset mid-stream: deassert rst_n with both stages full -> out_valid=0 and fk/r/s=0 immediately. After release, in_ready=1 and no stale result appears.
